fpga_cfg_loader: RTL and testbench
==================================

# fpga_cfg_loader

Configuration loader for the `fgpa` fabric. It accepts a byte-serial configuration stream over a valid/ready handshake and assembles it into 33-bit LUT configuration words (32-bit truth table plus register-select bit) and the switch-box mux configuration word. It writes each completed word into the fabric through one-hot write strobes, then raises a done/enable indication. It is the hardware producer of the configuration state that the fabric's LUTs (`l1`..`l16`) and `sb_mux` consume, replacing backdoor loading.

## Interface
- `NUM_LUT`, 16: number of LUTs configured, in order `l1`..`lNUM_LUT`.
- `SB_W`, 16: switch-box configuration width in bits; must be a multiple of 8.
- `clock` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `cfg_start` in 1: single-cycle pulse that arms or re-arms loading.
- `cfg_data` in 8: stream byte.
- `cfg_valid` in 1: `cfg_data` is valid.
- `cfg_ready` out 1: loader accepts a byte. A byte transfers on a cycle where `cfg_valid` and `cfg_ready` are both high.
- `lut_we` out NUM_LUT: one-hot LUT write strobe; bit i writes LUT i+1.
- `lut_wdata` out 33: bit 32 is the register select, bits 31:0 are the truth table.
- `sb_we` out 1: switch-box write strobe.
- `sb_wdata` out SB_W: switch-box configuration word.
- `cfg_done` out 1: level; the load sequence has terminated, either OK or with an error.
- `cfg_err` out 1: level; the load terminated with an error.
- `fabric_en` out 1: level; high when `cfg_done` is high and `cfg_err` is low.

## Operation
- Stream format, in order:
  - For each LUT i = 1..NUM_LUT, 5 bytes: 4 truth-table bytes, MSB byte first, then 1 flag byte. The flag byte's bit 0 is the register select; bits 7:1 are reserved and must be 0.
  - Then SB_W/8 switch-box bytes, MSB first.
  - Under `CFG_CHK_EN` only, then 1 checksum byte.
- States:
  - IDLE: `cfg_ready`=0.
  - LUT: byte counter 0..4 and LUT index 0..NUM_LUT-1.
  - SB: byte counter 0..SB_W/8-1.
  - CHK: only under `CFG_CHK_EN`.
  - DONE.
  - ERR.
- Transitions:
  - IDLE -> LUT on `cfg_start`.
  - LUT -> SB after the flag byte of the last LUT.
  - SB -> CHK, or SB -> DONE without the macro, after the last SB byte.
  - CHK -> DONE on checksum match, CHK -> ERR on mismatch.
  - LUT -> ERR on a flag byte with any of bits 7:1 set. That LUT is not written.
  - DONE and ERR hold until `reset` or `cfg_start`.
- `cfg_start` in any state, including LUT, SB, CHK, DONE and ERR, clears all counters, the shift register, the checksum, `cfg_done` and `cfg_err`, then enters LUT. LUT and switch-box words already written stay in the fabric; the loader does not roll them back.
- `cfg_ready` = (state is LUT, SB or CHK) and not `cfg_start`. A byte presented together with `cfg_start` is not accepted.
- Bytes shift into the 32-bit assembly register with a left shift: `{reg[23:0], cfg_data}`.
- `lut_wdata`/`sb_wdata` hold their last written value between strobes.

## Timing
- Reset values: `cfg_ready`=0, `lut_we`=0, `lut_wdata`=0, `sb_we`=0, `sb_wdata`=0, `cfg_done`=0, `cfg_err`=0, `fabric_en`=0. State is IDLE.
- Write latency:
  - `lut_we` pulses for exactly 1 cycle, in the cycle after the flag byte is accepted. `lut_wdata` is valid in that same cycle.
  - `sb_we` follows the same rule relative to the last SB byte.
- No back-pressure: `cfg_ready` stays high throughout LUT, SB and CHK, so a full-rate stream takes one byte per cycle.
- Without `CFG_CHK_EN`: `cfg_done` rises in the same cycle as `sb_we`.
- With `CFG_CHK_EN`: `cfg_done` rises 1 cycle after the checksum byte is accepted.
- `fabric_en` is registered and rises in the cycle after `cfg_done` rises.
- On entering ERR, `cfg_err` and `cfg_done` rise together, 1 cycle after the offending byte is accepted. `fabric_en` stays 0.
- Gaps in `cfg_valid` stall the loader without limit; there is no timeout.
- `reset` mid-load returns everything to its reset values on the next edge.

## Configuration
- `CFG_CHK_EN`:
  - Defined: the stream carries a trailing checksum byte equal to the XOR of every preceding stream byte. The loader checks it in CHK, and a mismatch ends the load in ERR.
  - Undefined: there is no CHK state, the stream is NUM_LUT*5 + SB_W/8 bytes long, and `cfg_err` is raised only by reserved-bit violations.

## Test plan
- Reset: hold `reset` for 3 cycles -> every output is 0 and `cfg_ready`=0, even with `cfg_valid`=1.
- Single LUT: `cfg_start`, then bytes 00 00 55 55 01 -> one cycle later `lut_we`=0x0001 and `lut_wdata`=0x1_00005555. No other strobes.
- Full load: 16 LUT words 0x00005555..0x0000FF00, with LUT13-16 at 0x00AACCF0 and reg bit 0, then SB bytes 84 21 -> 16 one-hot strobes in order and `sb_wdata`=0x8421 with `sb_we` pulsed. `cfg_done`=1, `fabric_en`=1 one cycle later, `cfg_err`=0.
- Reserved bit: flag byte 0x03 on LUT 2 -> no `lut_we[1]`; `cfg_err`=1 and `cfg_done`=1 one cycle later; `cfg_ready`=0; `fabric_en` stays 0.
- Restart: `cfg_start` after LUT 3 bytes, then a full valid stream -> counters restart at LUT1 and the load completes with `fabric_en`=1. A byte presented in the `cfg_start` cycle is not accepted.
- `CFG_CHK_EN`, full stream with the correct XOR byte -> `cfg_done`=1 and `cfg_err`=0. Repeat with the XOR byte inverted -> `cfg_err`=1 and `fabric_en`=0.

Source files
------------

// File: rtl/fpga_cfg_loader.sv
// -----------------------------------------------------------------------------
// fpga_cfg_loader
//
// Purpose: byte-serial configuration loader for the fabric. Assembles the
// incoming stream into 33-bit LUT configuration words (register select bit
// plus 32-bit truth table) and one switch-box mux word. Each word is written
// into the fabric with a one-cycle strobe. The loader then reports
// done / error / fabric enable.
//
// Stream: for each LUT, 4 truth-table bytes (MSB first) and 1 flag byte
// (bit 0 = register select, bits 7:1 reserved and must be zero). Then
// SB_W/8 switch-box bytes (MSB first). Then, only when CFG_CHK_EN is
// defined, a checksum byte equal to the XOR of all preceding bytes.
//
// Optional feature macro: CFG_CHK_EN (trailing checksum byte and CHK state).
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   cfg_start            one-cycle pulse that (re)arms loading from LUT 1
//   cfg_data/cfg_valid   stream byte and its valid flag
//   cfg_ready            loader accepts a byte this cycle
//   lut_we, lut_wdata    one-hot LUT write strobe and word {reg_sel, tt[31:0]}
//   sb_we, sb_wdata      switch-box write strobe and word
//   cfg_done, cfg_err    load terminated / terminated with an error (levels)
//   fabric_en            registered: done and no error
//   dbg_state            current FSM state, for observation only
//
// Handshake: a byte transfers on every rising edge where cfg_valid and
// cfg_ready are both high. cfg_ready never depends on cfg_valid. A byte
// presented together with cfg_start is not taken.
// -----------------------------------------------------------------------------
module fpga_cfg_loader #(
  parameter int NUM_LUT = 16,
  parameter int SB_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_start,
  input  logic [7:0]         cfg_data,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  output logic [NUM_LUT-1:0] lut_we,
  output logic [32:0]        lut_wdata,
  output logic               sb_we,
  output logic [SB_W-1:0]    sb_wdata,
  output logic               cfg_done,
  output logic               cfg_err,
  output logic               fabric_en,
  output logic [2:0]         dbg_state
);

  localparam int SB_BYTES = SB_W / 8;
  // The assembly register must hold a full switch-box word if it exceeds 32 bits.
  localparam int ASM_W    = (SB_W > 32) ? SB_W : 32;
  localparam int LIW      = (NUM_LUT > 1) ? $clog2(NUM_LUT) : 1;
  localparam int SBCW     = $clog2(SB_BYTES) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LUT  = 3'd1;
  localparam logic [2:0] S_SB   = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [NUM_LUT-1:0] LUT_ONE = NUM_LUT'(1);

  logic [2:0]         r_state;
  logic [2:0]         r_byte_cnt;
  logic [LIW-1:0]     r_lut_idx;
  logic [SBCW-1:0]    r_sb_cnt;
  logic [ASM_W-1:0]   r_shift;
  logic [NUM_LUT-1:0] r_lut_we;
  logic [32:0]        r_lut_wdata;
  logic               r_sb_we;
  logic [SB_W-1:0]    r_sb_wdata;
  logic               r_done;
  logic               r_err;
  logic               r_fabric_en;
`ifdef CFG_CHK_EN
  logic [7:0]         r_chk;
`endif

  logic               w_ready;
  logic               w_accept;
  logic [ASM_W-1:0]   w_shift_next;

  assign w_ready      = ((r_state == S_LUT) || (r_state == S_SB) || (r_state == S_CHK))
                        && !cfg_start;
  assign w_accept     = cfg_valid && w_ready;
  assign w_shift_next = {r_shift[ASM_W-9:0], cfg_data};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= '0;
      r_lut_idx   <= '0;
      r_sb_cnt    <= '0;
      r_shift     <= '0;
      r_lut_we    <= '0;
      r_lut_wdata <= '0;
      r_sb_we     <= 1'b0;
      r_sb_wdata  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_fabric_en <= 1'b0;
`ifdef CFG_CHK_EN
      r_chk       <= '0;
`endif
    end else begin
      // Strobes are single-cycle; fabric_en trails the done/err levels by one cycle.
      r_lut_we    <= '0;
      r_sb_we     <= 1'b0;
      r_fabric_en <= r_done && !r_err;
      if (cfg_start) begin
        // Restart from LUT 1. Words already written stay in the fabric,
        // and the write-data registers keep their last values.
        r_state     <= S_LUT;
        r_byte_cnt  <= '0;
        r_lut_idx   <= '0;
        r_sb_cnt    <= '0;
        r_shift     <= '0;
        r_done      <= 1'b0;
        r_err       <= 1'b0;
        r_fabric_en <= 1'b0;
`ifdef CFG_CHK_EN
        r_chk       <= '0;
`endif
      end else if (w_accept) begin
        r_shift <= w_shift_next;
`ifdef CFG_CHK_EN
        r_chk   <= r_chk ^ cfg_data;
`endif
        case (r_state)
          S_LUT: begin
            if (r_byte_cnt == 3'd4) begin
              // Flag byte: the truth table is already complete in r_shift.
              if (|cfg_data[7:1]) begin
                r_state <= S_ERR;
                r_done  <= 1'b1;
                r_err   <= 1'b1;
              end else begin
                r_lut_we    <= LUT_ONE << r_lut_idx;
                r_lut_wdata <= {cfg_data[0], r_shift[31:0]};
                r_byte_cnt  <= '0;
                if (r_lut_idx == LIW'(NUM_LUT - 1)) begin
                  r_lut_idx <= '0;
                  r_state   <= S_SB;
                end else begin
                  r_lut_idx <= r_lut_idx + 1'b1;
                end
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 3'd1;
            end
          end
          S_SB: begin
            if (r_sb_cnt == SBCW'(SB_BYTES - 1)) begin
              r_sb_we    <= 1'b1;
              r_sb_wdata <= w_shift_next[SB_W-1:0];
              r_sb_cnt   <= '0;
`ifdef CFG_CHK_EN
              r_state    <= S_CHK;
`else
              r_state    <= S_DONE;
              r_done     <= 1'b1;
`endif
            end else begin
              r_sb_cnt <= r_sb_cnt + 1'b1;
            end
          end
`ifdef CFG_CHK_EN
          S_CHK: begin
            // r_chk holds the XOR of every byte before this one.
            r_done <= 1'b1;
            if (cfg_data == r_chk) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign cfg_ready = w_ready;
  assign lut_we    = r_lut_we;
  assign lut_wdata = r_lut_wdata;
  assign sb_we     = r_sb_we;
  assign sb_wdata  = r_sb_wdata;
  assign cfg_done  = r_done;
  assign cfg_err   = r_err;
  assign fabric_en = r_fabric_en;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_fpga_cfg_loader: directed plus randomized bench for fpga_cfg_loader.
// Expected writes and end states come from a stream-level reference model.
// -----------------------------------------------------------------------------
module tb_fpga_cfg_loader;

  localparam int NUM_LUT  = 16;
  localparam int SB_W     = 16;
  localparam int SB_BYTES = SB_W / 8;
  localparam int EW       = NUM_LUT + 33;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic               cfg_start;
  logic [7:0]         cfg_data;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [NUM_LUT-1:0] lut_we;
  logic [32:0]        lut_wdata;
  logic               sb_we;
  logic [SB_W-1:0]    sb_wdata;
  logic               cfg_done;
  logic               cfg_err;
  logic               fabric_en;
  logic [2:0]         dbg_state;

  fpga_cfg_loader #(.NUM_LUT(NUM_LUT), .SB_W(SB_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_start (cfg_start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .lut_we    (lut_we),
    .lut_wdata (lut_wdata),
    .sb_we     (sb_we),
    .sb_wdata  (sb_wdata),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .fabric_en (fabric_en),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0]      stream[$];
  logic [31:0]     g_tt[NUM_LUT];
  logic            g_reg[NUM_LUT];
  logic [SB_W-1:0] g_sb;

  logic [EW-1:0]   exp_q[$];
  logic [EW-1:0]   obs_q[$];
  logic [SB_W-1:0] exp_sb_q[$];
  logic [SB_W-1:0] obs_sb_q[$];
  logic            exp_done, exp_err, exp_fen;
  int              n_consume;
  bit              g_abort;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Collect every fabric write away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (lut_we != '0) obs_q.push_back({lut_we, lut_wdata});
      if (sb_we)        obs_sb_q.push_back(sb_wdata);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stream generation and reference model ----------------
  task automatic gen_stream(input int bad_lut, input logic [7:0] bad_flag, input bit bad_chk);
    logic [7:0] x;
    stream.delete();
    for (int i = 0; i < NUM_LUT; i++) begin
      stream.push_back(g_tt[i][31:24]);
      stream.push_back(g_tt[i][23:16]);
      stream.push_back(g_tt[i][15:8]);
      stream.push_back(g_tt[i][7:0]);
      stream.push_back((i == bad_lut) ? bad_flag : {7'd0, g_reg[i]});
    end
    for (int k = 0; k < SB_BYTES; k++) stream.push_back(g_sb[SB_W-1-8*k -: 8]);
    x = 8'd0;
    foreach (stream[j]) x = x ^ stream[j];
`ifdef CFG_CHK_EN
    stream.push_back(bad_chk ? ~x : x);
`else
    if (bad_chk) x = 8'd0;
`endif
  endtask

  // Walks the byte stream by the format rules and appends expected writes.
  task automatic model_run();
    int p;
    logic [31:0]     tt;
    logic [7:0]      fl;
    logic [SB_W-1:0] sbw;
    logic [7:0]      x;
    p = 0;
    exp_done = 1'b1;
    exp_err  = 1'b0;
    for (int i = 0; i < NUM_LUT; i++) begin
      tt = {stream[p], stream[p+1], stream[p+2], stream[p+3]};
      fl = stream[p+4];
      p += 5;
      if (fl[7:1] != 7'd0) begin
        exp_err   = 1'b1;
        exp_fen   = 1'b0;
        n_consume = p;
        return;
      end
      exp_q.push_back({NUM_LUT'(1) << i, fl[0], tt});
    end
    sbw = '0;
    for (int k = 0; k < SB_BYTES; k++) begin
      sbw = (sbw << 8) | SB_W'(stream[p]);
      p++;
    end
    exp_sb_q.push_back(sbw);
`ifdef CFG_CHK_EN
    x = 8'd0;
    for (int q = 0; q < p; q++) x = x ^ stream[q];
    if (stream[p] !== x) exp_err = 1'b1;
    p++;
`else
    x = 8'd0;
`endif
    exp_fen   = !exp_err;
    n_consume = p;
  endtask

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_byte(input logic [7:0] b);
    int   budget;
    logic acc;
    budget    = 50;
    acc       = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = b;
    while (!acc && budget > 0) begin
      @(negedge clock);
      acc = cfg_ready;
      @(posedge clock);
      #1;
      budget--;
    end
    cfg_valid = 1'b0;
    check("byte_accept", 64'(acc), 64'(1));
    if (!acc) g_abort = 1'b1;
  endtask

  task automatic send_stream(input int n, input bit gaps);
    for (int p = 0; p < n && !g_abort; p++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clock);
          #1;
        end
      end
      send_byte(stream[p]);
    end
  endtask

  task automatic pulse_start(input bit with_byte);
    cfg_start = 1'b1;
    cfg_valid = with_byte;
    cfg_data  = 8'hA5;
    @(negedge clock);
    if (with_byte) check("ready_in_start_cycle", 64'(cfg_ready), 64'(0));
    @(posedge clock);
    #1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic end_checks(input string tag);
    @(negedge clock);
    check($sformatf("%s_done", tag), 64'(cfg_done), 64'(exp_done));
    check($sformatf("%s_err", tag), 64'(cfg_err), 64'(exp_err));
    check($sformatf("%s_fen_early", tag), 64'(fabric_en), 64'(0));
    check($sformatf("%s_ready_end", tag), 64'(cfg_ready), 64'(0));
    @(negedge clock);
    check($sformatf("%s_fen", tag), 64'(fabric_en), 64'(exp_fen));
    check($sformatf("%s_done_hold", tag), 64'(cfg_done), 64'(exp_done));
    @(posedge clock);
    #1;
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check($sformatf("%s_lut_count", tag), 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int j = 0; j < n; j++)
      check($sformatf("%s_lut_write%0d", tag, j), 64'(obs_q[j]), 64'(exp_q[j]));
    check($sformatf("%s_sb_count", tag), 64'(obs_sb_q.size()), 64'(exp_sb_q.size()));
    n = (obs_sb_q.size() < exp_sb_q.size()) ? obs_sb_q.size() : exp_sb_q.size();
    for (int j = 0; j < n; j++)
      check($sformatf("%s_sb_write%0d", tag, j), 64'(obs_sb_q[j]), 64'(exp_sb_q[j]));
    exp_q.delete();
    obs_q.delete();
    exp_sb_q.delete();
    obs_sb_q.delete();
  endtask

  task automatic run_scenario(input string tag, input bit gaps);
    g_abort = 1'b0;
    exp_q.delete();
    exp_sb_q.delete();
    obs_q.delete();
    obs_sb_q.delete();
    model_run();
    pulse_start(1'b0);
    send_stream(n_consume, gaps);
    end_checks(tag);
    compare_writes(tag);
  endtask

  task automatic load_table();
    logic [31:0] tbl[12];
    tbl = '{32'h00005555, 32'h00003333, 32'h00000F0F, 32'h000000FF,
            32'h0000AAAA, 32'h0000CCCC, 32'h0000F0F0, 32'h00006666,
            32'h00009999, 32'h00001234, 32'h00000FF0, 32'h0000FF00};
    for (int i = 0; i < NUM_LUT; i++) begin
      g_tt[i]  = (i < 12) ? tbl[i] : 32'h00AACCF0;
      g_reg[i] = (i < 12) ? ((i % 2) == 0) : 1'b0;
    end
    g_sb = 16'h8421;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [6:0] bf7;
    int         bad;
    bit         bchk;

    reset     = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = 8'hFF;
    g_abort   = 1'b0;

    // Reset held for 3 cycles with cfg_valid high.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", 64'(cfg_ready), 64'(0));
    check("rst_lut_we", 64'(lut_we), 64'(0));
    check("rst_lut_wdata", 64'(lut_wdata), 64'(0));
    check("rst_sb_we", 64'(sb_we), 64'(0));
    check("rst_sb_wdata", 64'(sb_wdata), 64'(0));
    check("rst_done", 64'(cfg_done), 64'(0));
    check("rst_err", 64'(cfg_err), 64'(0));
    check("rst_fen", 64'(fabric_en), 64'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("idle_ready", 64'(cfg_ready), 64'(0));
    @(posedge clock);
    #1;
    cfg_valid = 1'b0;

    // Single LUT: write appears exactly one cycle after the flag byte.
    obs_q.delete();
    obs_sb_q.delete();
    g_abort = 1'b0;
    pulse_start(1'b0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h55);
    send_byte(8'h55);
    send_byte(8'h01);
    @(negedge clock);
    check("single_lut_we", 64'(lut_we), 64'(16'h0001));
    check("single_lut_wdata", 64'(lut_wdata), 64'(33'h1_00005555));
    check("single_sb_we", 64'(sb_we), 64'(0));
    @(negedge clock);
    check("single_lut_we_pulse", 64'(lut_we), 64'(0));
    check("single_lut_wdata_hold", 64'(lut_wdata), 64'(33'h1_00005555));
    check("single_write_count", 64'(obs_q.size()), 64'(1));
    @(posedge clock);
    #1;

    // Full load at full rate.
    load_table();
    gen_stream(-1, 8'h00, 1'b0);
    run_scenario("full", 1'b0);
    check("full_sb_wdata", 64'(sb_wdata), 64'(16'h8421));

    // Reserved flag bit on LUT 2.
    gen_stream(1, 8'h03, 1'b0);
    run_scenario("resv", 1'b0);

    // Restart after two LUTs and three bytes, with a byte in the start cycle.
    g_abort = 1'b0;
    gen_stream(-1, 8'h00, 1'b0);
    exp_q.delete();
    exp_sb_q.delete();
    obs_q.delete();
    obs_sb_q.delete();
    model_run();
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    exp_sb_q.delete();
    model_run();
    pulse_start(1'b0);
    send_stream(13, 1'b0);
    pulse_start(1'b1);
    send_stream(n_consume, 1'b1);
    end_checks("restart");
    compare_writes("restart");

`ifdef CFG_CHK_EN
    load_table();
    gen_stream(-1, 8'h00, 1'b0);
    run_scenario("chk_good", 1'b0);
    gen_stream(-1, 8'h00, 1'b1);
    run_scenario("chk_bad", 1'b0);
`endif

    // Randomized loads with gaps and occasional reserved-bit violations.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NUM_LUT; i++) begin
        g_tt[i]  = $urandom;
        g_reg[i] = 1'($urandom_range(0, 1));
      end
      g_sb = SB_W'($urandom);
      bad  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NUM_LUT - 1)) : -1;
      bf7  = 7'($urandom_range(1, 127));
      bchk = ($urandom_range(0, 2) == 0);
      gen_stream(bad, {bf7, 1'($urandom_range(0, 1))}, bchk);
      run_scenario($sformatf("rand%0d", r), 1'b1);
    end

    // Reset in the middle of a load.
    g_abort = 1'b0;
    load_table();
    gen_stream(-1, 8'h00, 1'b0);
    pulse_start(1'b0);
    send_stream(7, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("midrst_ready", 64'(cfg_ready), 64'(0));
    check("midrst_lut_wdata", 64'(lut_wdata), 64'(0));
    check("midrst_sb_wdata", 64'(sb_wdata), 64'(0));
    check("midrst_done", 64'(cfg_done), 64'(0));
    check("midrst_fen", 64'(fabric_en), 64'(0));
    reset = 1'b0;
    @(posedge clock);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
